// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if
// Bundles the hazard inputs and the stall/kill/redirect outputs exchanged
// between the stall/flush sequencer and the F/X/W pipeline.
//   master : the sequencer (pipeline_ctrl); it reads the hazard and cache
//            status signals and drives the stage enables and perf_data.
//   slave  : the pipeline side; it drives the hazard and cache status
//            signals and consumes the stage enables.
// Signals:
//   ex_bubble, ex_do_jump           execute-stage hazard / taken jump
//   icache_ready                    fetch data valid this cycle
//   w_mem_req, dcache_ready         W-stage memory access and completion
//   f_stall, x_stall, w_stall       per-stage hold enables
//   x_kill, w_kill                  per-stage NOP insertion
//   pc_redirect                     PC loads jump target at next edge
//   perf_sel / perf_data            performance counter select and value
interface pipeline_ctrl_if #(
   parameter int CNT_W = 32
);
   logic             ex_bubble;
   logic             ex_do_jump;
   logic             icache_ready;
   logic             w_mem_req;
   logic             dcache_ready;
   logic             f_stall;
   logic             x_stall;
   logic             x_kill;
   logic             w_stall;
   logic             w_kill;
   logic             pc_redirect;
   logic [1:0]       perf_sel;
   logic [CNT_W-1:0] perf_data;

   modport master (
      input  ex_bubble, ex_do_jump, icache_ready, w_mem_req, dcache_ready,
      input  perf_sel,
      output f_stall, x_stall, x_kill, w_stall, w_kill, pc_redirect,
      output perf_data
   );

   modport slave (
      output ex_bubble, ex_do_jump, icache_ready, w_mem_req, dcache_ready,
      output perf_sel,
      input  f_stall, x_stall, x_kill, w_stall, w_kill, pc_redirect,
      input  perf_data
   );
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
// Stall/flush sequencer for the 3-stage F/X/W core. Combines the execute
// stage load-use bubble and taken-jump signals with the icache/dcache ready
// signals and produces per-stage hold/kill enables plus the PC redirect.
// Outputs are combinational from the current state and the inputs; only the
// state, the post-reset drain counter and the perf counters are registered.
// States:
//   RST_DRAIN : flush the pipe for RESET_CYCLES cycles after reset
//   RUN       : normal priority resolution
//   DWAIT     : full freeze until the outstanding data access completes
//   IDISCARD  : throw away the fetch that was in flight when a jump redirected
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : pipeline_ctrl_if.master (hazard inputs, stage enables, perf port)
// Parameters:
//   RESET_CYCLES : drain cycles after reset deassertion (>= 1)
//   CNT_W        : performance counter width
// Build option:
//   PIPE_PERF_EN : when defined, four wrap-around performance counters are
//                  built and selected by perf_sel; otherwise perf_data is 0.
module pipeline_ctrl #(
   parameter int RESET_CYCLES = 2,
   parameter int CNT_W        = 32
) (
   input logic             clk,
   input logic             rst,
   pipeline_ctrl_if.master bus
);

   typedef enum logic [1:0] {
      RST_DRAIN = 2'd0,
      RUN       = 2'd1,
      DWAIT     = 2'd2,
      IDISCARD  = 2'd3
   } state_t;

   localparam int DRAIN_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(RESET_CYCLES - 1);

   state_t               state_q, state_d;
   logic [DRAIN_W-1:0]   drain_q, drain_d;

   logic f_stall, x_stall, x_kill, w_stall, w_kill, pc_redirect;
   logic bubble_ins;
   logic freeze;

   // A W-stage access that has not completed stalls everything.
   assign freeze = bus.w_mem_req && !bus.dcache_ready;

   always_comb begin
      f_stall     = 1'b0;
      x_stall     = 1'b0;
      x_kill      = 1'b0;
      w_stall     = 1'b0;
      w_kill      = 1'b0;
      pc_redirect = 1'b0;
      bubble_ins  = 1'b0;
      state_d     = state_q;
      drain_d     = drain_q;

      case (state_q)
         RST_DRAIN: begin
            f_stall = 1'b1;
            x_kill  = 1'b1;
            w_kill  = 1'b1;
            if (drain_q == '0) begin
               state_d = RUN;
            end else begin
               drain_d = drain_q - 1'b1;
            end
         end

         RUN, DWAIT: begin
            // In DWAIT the freeze holds on dcache_ready alone; the access
            // that started it is still the one in W.
            if ((state_q == RUN && freeze) ||
                (state_q == DWAIT && !bus.dcache_ready)) begin
               f_stall = 1'b1;
               x_stall = 1'b1;
               w_stall = 1'b1;
               state_d = DWAIT;
            end else begin
               state_d = RUN;
               if (bus.ex_bubble) begin
                  // Jump operands are not valid under a load-use hazard,
                  // so ex_do_jump is deliberately ignored here.
                  f_stall    = 1'b1;
                  x_stall    = 1'b1;
                  w_kill     = 1'b1;
                  bubble_ins = 1'b1;
               end else if (bus.ex_do_jump) begin
                  pc_redirect = 1'b1;
                  x_kill      = 1'b1;
                  // The miss in flight belongs to the wrong path; drop it
                  // when it eventually returns.
                  if (!bus.icache_ready) begin
                     state_d = IDISCARD;
                  end
               end else if (!bus.icache_ready) begin
                  f_stall = 1'b1;
                  x_kill  = 1'b1;
               end
            end
         end

         IDISCARD: begin
            if (freeze) begin
               // X holds its NOP instead of reloading one so x_stall and
               // x_kill never overlap.
               f_stall = 1'b1;
               x_stall = 1'b1;
               w_stall = 1'b1;
            end else begin
               f_stall = 1'b1;
               x_kill  = 1'b1;
               if (bus.icache_ready) begin
                  state_d = RUN;
               end
            end
         end

         default: begin
            state_d = RST_DRAIN;
         end
      endcase
   end

   // The drain counter is reloaded by reset so that RESET_CYCLES drain cycles
   // follow every reset release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RST_DRAIN;
         drain_q <= DRAIN_INIT;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
      end
   end

   assign bus.f_stall     = f_stall;
   assign bus.x_stall     = x_stall;
   assign bus.x_kill      = x_kill;
   assign bus.w_stall     = w_stall;
   assign bus.w_kill      = w_kill;
   assign bus.pc_redirect = pc_redirect;

`ifdef PIPE_PERF_EN
   // Counter events: 0 = active (non-drain) cycle, 1 = W stalled,
   // 2 = load-use bubble inserted, 3 = redirect.
   logic [3:0]            perf_inc;
   logic [3:0][CNT_W-1:0] perf_vals;

   assign perf_inc = {pc_redirect, bubble_ins, w_stall, (state_q != RST_DRAIN)};

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_perf
         logic [CNT_W-1:0] cnt_q, cnt_d;

         always_comb begin
            cnt_d = cnt_q + CNT_W'(perf_inc[gi]);
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end

         assign perf_vals[gi] = cnt_q;
      end
   endgenerate

   assign bus.perf_data = perf_vals[bus.perf_sel];
`else
   logic unused_perf;
   assign unused_perf   = ^{bus.perf_sel, bubble_ins};
   assign bus.perf_data = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl
// Scoreboard bench for pipeline_ctrl. Each scenario task drives one input
// vector per cycle, pushes the expected output vector to a queue, and pops
// and compares it at the following falling edge.
// Input vector bits  : {ex_bubble, ex_do_jump, icache_ready, w_mem_req, dcache_ready}
// Output vector bits : {f_stall, x_stall, x_kill, w_stall, w_kill, pc_redirect}
module tb_pipeline_ctrl;
   localparam int CNT_W = 32;
`ifdef PIPE_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   logic [5:0] exp_q[$];
   logic [5:0] outs;

   pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

   pipeline_ctrl #(
      .RESET_CYCLES (2),
      .CNT_W        (CNT_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign outs = {bus.f_stall, bus.x_stall, bus.x_kill,
                  bus.w_stall, bus.w_kill, bus.pc_redirect};

   // Apply one input vector and record what the sequencer must answer.
   task automatic drive(input logic [4:0] s, input logic [5:0] e);
      {bus.ex_bubble, bus.ex_do_jump, bus.icache_ready,
       bus.w_mem_req, bus.dcache_ready} = s;
      exp_q.push_back(e);
   endtask

   task automatic test_reset();
      logic [4:0]       stim [0:2];
      logic [5:0]       expv [0:2];
      logic [5:0]       want;
      logic [CNT_W-1:0] pwant;
      stim = '{5'b00101, 5'b00101, 5'b00101};
      expv = '{6'b101010, 6'b101010, 6'b000000};
      rst = 1'b1;
      bus.perf_sel = 2'd0;
      drive(5'b00101, 6'b101010);
      repeat (2) @(posedge clk);
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (outs !== want) begin
         errors++;
         $display("FAIL reset_hold outs=%b want=%b", outs, want);
      end else $display("reset_hold outs=%b", outs);
      checks++;
      if (bus.perf_data !== '0) begin
         errors++;
         $display("FAIL reset_perf got=%0d want=0", bus.perf_data);
      end else $display("reset_perf perf_data=%0d", bus.perf_data);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(stim[i], expv[i]);
         @(negedge clk);
         want = exp_q.pop_front();
         checks++;
         if (outs !== want) begin
            errors++;
            $display("FAIL drain[%0d] outs=%b want=%b", i, outs, want);
         end else $display("drain[%0d] outs=%b", i, outs);
         @(posedge clk); #1;
      end
      bus.perf_sel = 2'd0; #1;
      pwant = PERF ? CNT_W'(1) : '0;
      checks++;
      if (bus.perf_data !== pwant) begin
         errors++;
         $display("FAIL perf_active got=%0d want=%0d", bus.perf_data, pwant);
      end else $display("perf_active perf_data=%0d", bus.perf_data);
   endtask

   task automatic test_load_use();
      logic [4:0]       stim [0:2];
      logic [5:0]       expv [0:2];
      logic [5:0]       want;
      logic [CNT_W-1:0] pwant;
      stim = '{5'b00101, 5'b10101, 5'b00101};
      expv = '{6'b000000, 6'b110010, 6'b000000};
      for (int i = 0; i < 3; i++) begin
         drive(stim[i], expv[i]);
         @(negedge clk);
         want = exp_q.pop_front();
         checks++;
         if (outs !== want) begin
            errors++;
            $display("FAIL load_use[%0d] outs=%b want=%b", i, outs, want);
         end else $display("load_use[%0d] outs=%b", i, outs);
         @(posedge clk); #1;
      end
      bus.perf_sel = 2'd2; #1;
      pwant = PERF ? CNT_W'(1) : '0;
      checks++;
      if (bus.perf_data !== pwant) begin
         errors++;
         $display("FAIL perf_bubbles got=%0d want=%0d", bus.perf_data, pwant);
      end else $display("perf_bubbles perf_data=%0d", bus.perf_data);
   endtask

   task automatic test_jump_bubble();
      logic [4:0]       stim [0:2];
      logic [5:0]       expv [0:2];
      logic [5:0]       want;
      logic [CNT_W-1:0] pwant;
      stim = '{5'b11101, 5'b01101, 5'b00101};
      expv = '{6'b110010, 6'b001001, 6'b000000};
      for (int i = 0; i < 3; i++) begin
         drive(stim[i], expv[i]);
         @(negedge clk);
         want = exp_q.pop_front();
         checks++;
         if (outs !== want) begin
            errors++;
            $display("FAIL jump_bubble[%0d] outs=%b want=%b", i, outs, want);
         end else $display("jump_bubble[%0d] outs=%b", i, outs);
         @(posedge clk); #1;
      end
      bus.perf_sel = 2'd3; #1;
      pwant = PERF ? CNT_W'(1) : '0;
      checks++;
      if (bus.perf_data !== pwant) begin
         errors++;
         $display("FAIL perf_redirects got=%0d want=%0d", bus.perf_data, pwant);
      end else $display("perf_redirects perf_data=%0d", bus.perf_data);
   endtask

   task automatic test_dcache_miss();
      logic [4:0]       stim [0:4];
      logic [5:0]       expv [0:4];
      logic [5:0]       want;
      logic [CNT_W-1:0] pwant;
      stim = '{5'b01110, 5'b01110, 5'b01110, 5'b01111, 5'b00101};
      expv = '{6'b110100, 6'b110100, 6'b110100, 6'b001001, 6'b000000};
      for (int i = 0; i < 5; i++) begin
         drive(stim[i], expv[i]);
         @(negedge clk);
         want = exp_q.pop_front();
         checks++;
         if (outs !== want) begin
            errors++;
            $display("FAIL dcache_miss[%0d] outs=%b want=%b", i, outs, want);
         end else $display("dcache_miss[%0d] outs=%b", i, outs);
         @(posedge clk); #1;
      end
      bus.perf_sel = 2'd1; #1;
      pwant = PERF ? CNT_W'(3) : '0;
      checks++;
      if (bus.perf_data !== pwant) begin
         errors++;
         $display("FAIL perf_wstall got=%0d want=%0d", bus.perf_data, pwant);
      end else $display("perf_wstall perf_data=%0d", bus.perf_data);
      bus.perf_sel = 2'd3; #1;
      pwant = PERF ? CNT_W'(2) : '0;
      checks++;
      if (bus.perf_data !== pwant) begin
         errors++;
         $display("FAIL perf_redirects2 got=%0d want=%0d", bus.perf_data, pwant);
      end else $display("perf_redirects2 perf_data=%0d", bus.perf_data);
   endtask

   task automatic test_redirect_imiss();
      logic [4:0] stim [0:4];
      logic [5:0] expv [0:4];
      logic [5:0] want;
      stim = '{5'b01001, 5'b00001, 5'b00001, 5'b00101, 5'b00101};
      expv = '{6'b001001, 6'b101000, 6'b101000, 6'b101000, 6'b000000};
      for (int i = 0; i < 5; i++) begin
         drive(stim[i], expv[i]);
         @(negedge clk);
         want = exp_q.pop_front();
         checks++;
         if (outs !== want) begin
            errors++;
            $display("FAIL redirect_imiss[%0d] outs=%b want=%b", i, outs, want);
         end else $display("redirect_imiss[%0d] outs=%b", i, outs);
         @(posedge clk); #1;
      end
   endtask

   task automatic test_idiscard_freeze();
      logic [4:0] stim [0:4];
      logic [5:0] expv [0:4];
      logic [5:0] want;
      stim = '{5'b01001, 5'b00010, 5'b00001, 5'b00101, 5'b00101};
      expv = '{6'b001001, 6'b110100, 6'b101000, 6'b101000, 6'b000000};
      for (int i = 0; i < 5; i++) begin
         drive(stim[i], expv[i]);
         @(negedge clk);
         want = exp_q.pop_front();
         checks++;
         if (outs !== want) begin
            errors++;
            $display("FAIL idiscard_freeze[%0d] outs=%b want=%b", i, outs, want);
         end else $display("idiscard_freeze[%0d] outs=%b", i, outs);
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0] stim [0:6];
      logic [5:0] expv [0:6];
      logic [5:0] want;
      // fetch miss, recover, freeze with pending bubble, load-use on the
      // DWAIT exit cycle, two consecutive jumps, idle
      stim = '{5'b00001, 5'b00101, 5'b10110, 5'b10111,
               5'b01101, 5'b01101, 5'b00101};
      expv = '{6'b101000, 6'b000000, 6'b110100, 6'b110010,
               6'b001001, 6'b001001, 6'b000000};
      for (int i = 0; i < 7; i++) begin
         drive(stim[i], expv[i]);
         @(negedge clk);
         want = exp_q.pop_front();
         checks++;
         if (outs !== want) begin
            errors++;
            $display("FAIL back_to_back[%0d] outs=%b want=%b", i, outs, want);
         end else $display("back_to_back[%0d] outs=%b", i, outs);
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_midop();
      logic [4:0] stim [0:2];
      logic [5:0] expv [0:2];
      logic [5:0] want;
      stim = '{5'b00101, 5'b00101, 5'b00101};
      expv = '{6'b101010, 6'b101010, 6'b000000};
      drive(5'b00110, 6'b110100);
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (outs !== want) begin
         errors++;
         $display("FAIL midop_enter outs=%b want=%b", outs, want);
      end else $display("midop_enter outs=%b", outs);
      @(posedge clk); #1;
      drive(5'b00110, 6'b110100);
      #1;
      want = exp_q.pop_front();
      checks++;
      if (outs !== want) begin
         errors++;
         $display("FAIL midop_dwait outs=%b want=%b", outs, want);
      end else $display("midop_dwait outs=%b", outs);
      // Reset between clock edges: outputs must change without a clock.
      rst = 1'b1;
      exp_q.push_back(6'b101010);
      #1;
      want = exp_q.pop_front();
      checks++;
      if (outs !== want) begin
         errors++;
         $display("FAIL midop_async_rst outs=%b want=%b", outs, want);
      end else $display("midop_async_rst outs=%b", outs);
      for (int s = 0; s < 4; s++) begin
         bus.perf_sel = 2'(s); #1;
         checks++;
         if (bus.perf_data !== '0) begin
            errors++;
            $display("FAIL midop_perf[%0d] got=%0d want=0", s, bus.perf_data);
         end else $display("midop_perf[%0d] perf_data=%0d", s, bus.perf_data);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(stim[i], expv[i]);
         @(negedge clk);
         want = exp_q.pop_front();
         checks++;
         if (outs !== want) begin
            errors++;
            $display("FAIL midop_drain[%0d] outs=%b want=%b", i, outs, want);
         end else $display("midop_drain[%0d] outs=%b", i, outs);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      bus.perf_sel = 2'd0;
      {bus.ex_bubble, bus.ex_do_jump, bus.icache_ready,
       bus.w_mem_req, bus.dcache_ready} = 5'b00101;
      test_reset();
      test_load_use();
      test_jump_bubble();
      test_dcache_miss();
      test_redirect_imiss();
      test_idiscard_freeze();
      test_back_to_back();
      test_reset_midop();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_left got=%0d want=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout reached");
      $fatal(1, "watchdog");
   end
endmodule
